// File: rtl/ascon_pkg.sv
// Shared constants and types for the Ascon input path.
package ascon_pkg;

    localparam int ASCON_BLK_W = 128;
    localparam int WORD_W      = 32;
    localparam logic [7:0] PAD_BYTE = 8'h80;

    typedef enum logic [1:0] {
        S_AD   = 2'd0,
        S_PT   = 2'd1,
        S_PAD  = 2'd2,
        S_HOLD = 2'd3
    } state_e;

    // Keeps the leading nb bytes of a word (byte 0 lives in [31:24]).
    function automatic logic [WORD_W-1:0] byte_mask(input logic [2:0] nb);
        case (nb)
            3'd0:    byte_mask = 32'h0000_0000;
            3'd1:    byte_mask = 32'hFF00_0000;
            3'd2:    byte_mask = 32'hFFFF_0000;
            3'd3:    byte_mask = 32'hFFFF_FF00;
            default: byte_mask = 32'hFFFF_FFFF;
        endcase
    endfunction

endpackage

// File: rtl/ascon_blk_fifo.sv
// Block FIFO, DEPTH x W. A push on a full FIFO is honoured only alongside a pop.
module ascon_blk_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 128
) (
    input  logic                       clk,
    input  logic                       i_rst,
    input  logic                       push,
    input  logic [W-1:0]               wdata,
    input  logic                       pop,
    output logic [W-1:0]               rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          push_ok, pop_ok;

    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;
    assign rdata   = mem_q[rptr_q];
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (push_ok) wptr_d = wptr_q + 1'b1;
        if (pop_ok)  rptr_d = rptr_q + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge i_rst) begin
        if (!i_rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage is not reset; pointers alone define what is visible.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q] <= wdata;
    end

endmodule

// File: rtl/ascon_in_packer.sv
// Packs AD/PT word streams into 10*-padded 128-bit blocks for ascon_enc,
// buffers them, and tracks per-segment block counts.
module ascon_in_packer
    import ascon_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int LEN_W = 10
) (
    input  logic                   clk,
    input  logic                   i_rst,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [WORD_W-1:0]      s_data,
    input  logic                   s_type,
    input  logic                   s_last,
    input  logic [2:0]             s_bytes,
    input  logic                   i_nxt_data,
    output logic [ASCON_BLK_W-1:0] o_data,
    output logic [LEN_W-1:0]       o_a_len,
    output logic [LEN_W-1:0]       o_m_len,
    output logic                   o_msg_ready,
    output logic                   o_err,
    output logic                   o_underflow
);

    localparam logic [LEN_W-1:0] LEN_MAX = '1;
    localparam logic [ASCON_BLK_W-1:0] PAD_BLK = {PAD_BYTE, {(ASCON_BLK_W-8){1'b0}}};

    state_e                 state_q, state_d;
    logic [ASCON_BLK_W-1:0] acc_q, acc_d, data_q, data_d, blk, push_blk;
    logic [1:0]             widx_q, widx_d;
    logic                   pad_seg_q, pad_seg_d, err_q, err_d, uf_q, uf_d;
    logic [LEN_W-1:0]       a_len_q, a_len_d, m_len_q, m_len_d;
    logic                   push, push_seg;
    logic [2:0]             nb;
    logic [4:0]             off;
    logic [6:0]             wbase, pbase;
    logic [ASCON_BLK_W-1:0] fifo_head;
    logic                   fifo_full, fifo_empty;
    logic [$clog2(DEPTH):0] fifo_cnt;

    ascon_blk_fifo #(.DEPTH(DEPTH), .W(ASCON_BLK_W)) u_fifo (
        .clk   (clk),
        .i_rst (i_rst),
        .push  (push),
        .wdata (push_blk),
        .pop   (i_nxt_data),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    assign s_ready     = ((state_q == S_AD) || (state_q == S_PT)) && !fifo_full;
    assign o_data      = data_q;
    assign o_a_len     = a_len_q;
    assign o_m_len     = m_len_q;
    assign o_msg_ready = (state_q == S_HOLD);
    assign o_err       = err_q;
    assign o_underflow = uf_q;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        widx_d    = widx_q;
        pad_seg_d = pad_seg_q;
        err_d     = err_q;
        a_len_d   = a_len_q;
        m_len_d   = m_len_q;
        push      = 1'b0;
        push_blk  = '0;
        push_seg  = (state_q == S_PT);
        nb        = (s_last && (s_bytes <= 3'd4)) ? s_bytes : 3'd4;
        off       = {1'b0, widx_q, 2'b00} + {2'b00, nb};
        wbase     = 7'd127 - {widx_q, 5'd0};
        pbase     = 7'd127 - {off[3:0], 3'b000};
        blk       = acc_q;
        blk[wbase -: WORD_W] = s_data & byte_mask(nb);

        case (state_q)
            S_AD, S_PT: begin
                if (s_valid && s_ready) begin
                    if (s_type != (state_q == S_PT)) begin
                        err_d = 1'b1;
                    end else begin
                        if (s_last && (s_bytes > 3'd4)) err_d = 1'b1;
                        if (s_last) begin
                            acc_d  = '0;
                            widx_d = '0;
                            push   = 1'b1;
                            // off==16: data ends on a block boundary, pad goes in its own block
                            if (off[4]) begin
                                push_blk  = blk;
                                pad_seg_d = (state_q == S_PT);
                                state_d   = S_PAD;
                            end else begin
                                push_blk = blk;
                                push_blk[pbase -: 8] = PAD_BYTE;
                                state_d  = (state_q == S_PT) ? S_HOLD : S_PT;
                            end
                        end else if (widx_q == 2'd3) begin
                            push     = 1'b1;
                            push_blk = blk;
                            acc_d    = '0;
                            widx_d   = '0;
                        end else begin
                            acc_d  = blk;
                            widx_d = widx_q + 2'd1;
                        end
                    end
                end
            end
            S_PAD: begin
                push_seg = pad_seg_q;
                if (!fifo_full) begin
                    push     = 1'b1;
                    push_blk = PAD_BLK;
                    state_d  = pad_seg_q ? S_HOLD : S_PT;
                end
            end
            default: begin
                if (fifo_cnt == '0) begin
                    state_d = S_AD;
                    a_len_d = '0;
                    m_len_d = '0;
                end
            end
        endcase

        if (push) begin
            if (push_seg) begin
                if (m_len_q == LEN_MAX) err_d = 1'b1;
                else                    m_len_d = m_len_q + 1'b1;
            end else begin
                if (a_len_q == LEN_MAX) err_d = 1'b1;
                else                    a_len_d = a_len_q + 1'b1;
            end
        end

        data_d = data_q;
        uf_d   = uf_q;
        if (i_nxt_data) begin
            data_d = fifo_empty ? '0 : fifo_head;
            if (fifo_empty) uf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q   <= S_AD;
            acc_q     <= '0;
            widx_q    <= '0;
            pad_seg_q <= 1'b0;
            err_q     <= 1'b0;
            uf_q      <= 1'b0;
            a_len_q   <= '0;
            m_len_q   <= '0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            widx_q    <= widx_d;
            pad_seg_q <= pad_seg_d;
            err_q     <= err_d;
            uf_q      <= uf_d;
            a_len_q   <= a_len_d;
            m_len_q   <= m_len_d;
            data_q    <= data_d;
        end
    end

endmodule
